bk_adder_pipe: RTL
==================

BK_ADDER_PIPE -- requirements
Module: bk_adder_pipe

Interface
REQ-001 Parameter: WIDTH, default 12, operand width in bits; legal range 2..64.
REQ-002 Parameter: STAGES, default 2, number of register stages from accepted input to output; legal range 1..(ceil(log2(WIDTH))+1).
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset; synchronous, active-low.
REQ-005 Port: in_valid  input  1  operand beat valid.
REQ-006 Port: in_ready  output  1  block can accept a beat this cycle.
REQ-007 Port: in_a  input  WIDTH  operand A, unsigned.
REQ-008 Port: in_b  input  WIDTH  operand B, unsigned.
REQ-009 Port: in_cin  input  1  carry-in.
REQ-010 Port: in_sub  input  1  subtract select; present only with BK_SUB_EN.
REQ-011 Port: out_valid  output  1  result beat valid.
REQ-012 Port: out_ready  input  1  downstream accepts result.
REQ-013 Port: out_sum  output  WIDTH+1  result; MSB is carry-out.

Function
REQ-014 Addition SHALL use a Brent-Kung parallel-prefix carry network: per-bit generate g=a&b, propagate p=a^b, up-sweep then down-sweep of (G,P) pairs, sum = p ^ carry.
REQ-015 out_sum SHALL equal {1'b0,in_a} + {1'b0,in_b} + in_cin, modulo 2^(WIDTH+1); no truncation of carry-out.
REQ-016 Prefix levels SHALL be distributed evenly across STAGES register stages; result appears exactly STAGES cycles after acceptance when no stall occurs.
REQ-017 A beat is accepted on a rising edge with in_valid=1 and in_ready=1; a result is consumed on a rising edge with out_valid=1 and out_ready=1.
REQ-018 Pipeline SHALL advance as a unit; advance = out_ready | ~out_valid; in_ready = advance (combinational).
REQ-019 When advance=0, all stage registers including out_sum and out_valid SHALL hold; out_sum SHALL stay stable while out_valid=1 and out_ready=0.
REQ-020 When advance=1 and in_valid=0, a bubble (valid=0) SHALL enter stage 1; bubbles SHALL propagate and never raise out_valid.
REQ-021 Throughput SHALL be one result per cycle with out_ready held 1; no bubble inserted between back-to-back beats.
REQ-022 Results SHALL emerge in acceptance order; no beat dropped or duplicated under any in_valid/out_ready pattern.
REQ-023 Operand registers SHALL capture in_a/in_b/in_cin only on acceptance; values on non-accepted cycles SHALL not affect any result.
REQ-024 Boundary: all-ones + all-ones + cin=1 SHALL yield {1'b1, all-ones}; zero + zero + 0 SHALL yield zero.

Reset
REQ-025 While rst_n=0 at a rising edge: all stage valid bits, out_valid SHALL become 0; out_sum SHALL become 0.
REQ-026 Reset mid-operation SHALL discard every in-flight beat; no result from a pre-reset beat SHALL ever appear.
REQ-027 in_ready SHALL be 1 on the first cycle after rst_n returns to 1.
REQ-028 Data registers other than out_sum need no reset.

Configuration
REQ-029 Macro BK_SUB_EN SHALL compile in port in_sub and subtraction mode.
REQ-030 With BK_SUB_EN and in_sub=1 on acceptance: result = {1'b0,in_a} + {1'b0,~in_b} + 1, in_cin ignored; out_sum MSB=1 means no borrow (a>=b).
REQ-031 With BK_SUB_EN and in_sub=0: behaviour identical to REQ-015.
REQ-032 Without BK_SUB_EN: port in_sub absent; block performs addition only; no inversion logic present.

Verification (WIDTH=12, STAGES=2)
REQ-033 Accept a=0xFFF, b=0x001, cin=0, out_ready=1 -> out_valid=1 two cycles later, out_sum=0x1000.
REQ-034 Back-to-back beats (0x123+0x456, 0x800+0x800, 0xFFF+0xFFF cin=1) -> out_sum 0x579, 0x1000, 0x1FFF on consecutive cycles.
REQ-035 Hold out_ready=0 for 5 cycles with 3 beats offered -> in_ready=0 once full, out_sum frozen, all 3 results later delivered in order.
REQ-036 Assert rst_n=0 for 1 cycle with 2 beats in flight -> out_valid=0 next cycle, out_sum=0x000, no stale result afterwards.
REQ-037 BK_SUB_EN: a=0x005, b=0x007, in_sub=1 -> out_sum=0x0FFE (MSB 0, borrow); a=0x007, b=0x005 -> 0x1002.
REQ-038 Random 10^5 beats with random in_valid/out_ready against reference model -> zero mismatches, zero lost beats.

Source files
------------

// File: rtl/bk_adder_pipe.sv
// Pipelined Brent-Kung adder with valid/ready flow control; the pipeline advances as one unit.
// Define BK_SUB_EN to add the in_sub port and subtract mode (a + ~b + 1).
module bk_adder_pipe #(
  parameter int unsigned WIDTH  = 12,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef BK_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum
);

  localparam int unsigned LOG_W = $clog2(WIDTH);
  localparam int unsigned N_LVL = 2 * LOG_W - 1;

  // gg/pp: group generate/propagate being reduced; p: bitwise propagate kept for the sum
  typedef struct packed {
    logic [WIDTH-1:0] gg;
    logic [WIDTH-1:0] pp;
    logic [WIDTH-1:0] p;
    logic             cin;
  } gp_t;

  // Carry-in is folded into bit 0's generate so prefix G[i] is the carry out of bit i.
  function automatic gp_t pg_gen(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic c);
    gp_t y;
    y.gg    = a & b;
    y.pp    = a ^ b;
    y.p     = a ^ b;
    y.cin   = c;
    y.gg[0] = y.gg[0] | (y.pp[0] & c);
    return y;
  endfunction

  // Levels 0..LOG_W-1 are the up-sweep, the remaining LOG_W-1 levels the down-sweep.
  function automatic gp_t bk_level(input gp_t x, input int unsigned k);
    gp_t         y;
    int unsigned d;
    y = x;
    if (k < LOG_W) begin
      d = 32'd1 << k;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if ((i + 1) % (2 * d) == 0) begin
          y.gg[i] = x.gg[i] | (x.pp[i] & x.gg[i - d]);
          y.pp[i] = x.pp[i] & x.pp[i - d];
        end
      end
    end else begin
      d = 32'd1 << (N_LVL - 1 - k);
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (i >= 2 * d && (i + 1) % (2 * d) == d) begin
          y.gg[i] = x.gg[i] | (x.pp[i] & x.gg[i - d]);
          y.pp[i] = x.pp[i] & x.pp[i - d];
        end
      end
    end
    return y;
  endfunction

  function automatic gp_t bk_range(input gp_t x, input int unsigned lo, input int unsigned hi);
    gp_t y;
    y = x;
    for (int unsigned k = lo; k < hi; k++) y = bk_level(y, k);
    return y;
  endfunction

  // Prefix level boundary at the input of stage j; spreads levels evenly over the stages.
  function automatic int unsigned cut(input int unsigned j);
    return (j * N_LVL) / STAGES;
  endfunction

  function automatic logic [WIDTH:0] finalize(input gp_t x);
    logic [WIDTH-1:0] c;
    c = {x.gg[WIDTH-2:0], x.cin};
    return {x.gg[WIDTH-1], x.p ^ c};
  endfunction

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             advance;
  gp_t              pg_in;
  gp_t              last_src;
  logic             last_vld;

`ifdef BK_SUB_EN
  assign b_eff   = in_sub ? ~in_b : in_b;
  assign cin_eff = in_sub | in_cin;
`else
  assign b_eff   = in_b;
  assign cin_eff = in_cin;
`endif

  assign pg_in    = pg_gen(in_a, b_eff, cin_eff);
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  if (STAGES == 1) begin : g_flat
    assign last_src = pg_in;
    assign last_vld = in_valid;
  end else begin : g_pipe
    localparam int unsigned NR = STAGES - 1;

    gp_t           stage_in [NR];
    gp_t           nxt      [NR];
    gp_t           pipe     [NR];
    logic [NR-1:0] vld;
    logic [NR-1:0] ld;

    always_comb begin
      stage_in[0] = pg_in;
      for (int unsigned j = 1; j < NR; j++) stage_in[j] = pipe[j-1];
      for (int unsigned j = 0; j < NR; j++) nxt[j] = bk_range(stage_in[j], cut(j), cut(j + 1));
    end

    // Data registers load only for valid beats, so bubbles and idle inputs never disturb them.
    assign ld = NR'({vld, in_valid}) & {NR{advance}};

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld <= '0;
      end else if (advance) begin
        vld <= NR'({vld, in_valid});
      end
    end

    always_ff @(posedge clk) begin
      for (int unsigned j = 0; j < NR; j++) begin
        if (ld[j]) pipe[j] <= nxt[j];
      end
    end

    assign last_src = pipe[NR-1];
    assign last_vld = vld[NR-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else if (advance) begin
      out_valid <= last_vld;
      if (last_vld) out_sum <= finalize(bk_range(last_src, cut(STAGES - 1), N_LVL));
    end
  end

endmodule
